// File: rtl/serial_addsub_ctrl_pkg.sv
// +----------------------------------------------------------------+
// | addsub_pkg : shared types/helpers for serial_addsub_ctrl        |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
`default_nettype none

package addsub_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } addsub_state_e;

  // Operands already carry the inverted B for subtraction.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ripple_carry_adder.sv
// +----------------------------------------------------------------+
// | ripple_carry_adder : 4-bit ripple-carry adder slice             |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
`default_nettype none

module ripple_carry_adder
  import addsub_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_c,
  output logic [SLICE_W-1:0] o_s,
  output logic               o_c
);

  logic [SLICE_W:0] w_c;

  assign w_c[0] = i_c;

  for (genvar g = 0; g < SLICE_W; g++) begin : g_fa
    assign o_s[g]     = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g + 1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_c = w_c[SLICE_W];

endmodule

`default_nettype wire

// File: rtl/serial_addsub_ctrl.sv
// +----------------------------------------------------------------+
// | serial_addsub_ctrl : WIDTH-bit add/sub, one nibble per cycle    |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
`default_nettype none

module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             ovf_o
);

  localparam int NUM_SLICES = WIDTH / SLICE_W;
  localparam int KW         = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_SLICES - 1);

  if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_width_check
    $error("serial_addsub_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  addsub_state_e r_state;
  addsub_state_e w_state_nxt;

  logic [KW-1:0]      r_k;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [WIDTH-1:0]   r_s;
  logic               r_c;
  logic               r_ovf;

  logic [SLICE_W-1:0] w_sl_a;
  logic [SLICE_W-1:0] w_sl_b;
  logic [SLICE_W-1:0] w_sl_s;
  logic               w_sl_c;
  logic               w_accept;
  logic               w_last;

  assign w_accept = in_valid_i && (r_state == IDLE);
  assign w_last   = (r_k == K_LAST);
  assign w_sl_a   = r_a[int'(r_k) * SLICE_W +: SLICE_W];
  assign w_sl_b   = r_b[int'(r_k) * SLICE_W +: SLICE_W];

  ripple_carry_adder u_slice (
    .i_a (w_sl_a),
    .i_b (w_sl_b),
    .i_c (r_carry),
    .o_s (w_sl_s),
    .o_c (w_sl_c)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = CALC;
      CALC:    if (w_last) w_state_nxt = DONE;
      DONE:    if (out_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (r_state == IDLE);
    out_valid_o = (r_state == DONE);
  end

  // Subtraction is A + ~B + 1, with the +1 entering as the initial carry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_s     <= '0;
      r_c     <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a_i;
      r_b     <= sub_i ? ~b_i : b_i;
      r_carry <= sub_i;
      r_k     <= '0;
    end else if (r_state == CALC) begin
      r_s[int'(r_k) * SLICE_W +: SLICE_W] <= w_sl_s;
      r_carry <= w_sl_c;
      if (w_last) begin
        r_c   <= w_sl_c;
        r_ovf <= signed_ovf(r_a[WIDTH-1], r_b[WIDTH-1], w_sl_s[SLICE_W-1]);
      end else begin
        r_k <= r_k + KW'(1);
      end
    end
  end

  assign s_o   = r_s;
  assign c_o   = r_c;
  assign ovf_o = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub_ctrl.sv
// +----------------------------------------------------------------+
// | tb_serial_addsub_ctrl : directed bench with result scoreboard   |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_serial_addsub_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b1;
  logic         in_valid = 1'b0;
  logic         sub = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] s;
  logic         c;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   acc_cyc[$];

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .sub_i       (sub),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .s_o         (s),
    .c_o         (c),
    .ovf_o       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic, overflow from the true signed result.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub);
    exp_t       e;
    logic [W:0] r;
    int         t;
    if (msub) begin
      r = {1'b0, ma} - {1'b0, mb};
      r[W] = (ma >= mb);
      t = int'($signed(ma)) - int'($signed(mb));
    end else begin
      r = {1'b0, ma} + {1'b0, mb};
      t = int'($signed(ma)) + int'($signed(mb));
    end
    e.s   = r[W-1:0];
    e.c   = r[W];
    e.ovf = (t > 32767) || (t < -32768);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_ni) begin
      if (in_valid && in_ready) begin
        sb.push_back(model(a, b, sub));
        acc_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_underflow: observed=result expected=no result");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_s", 32'(s), 32'(e.s));
          chk("sb_c", 32'(c), 32'(e.c));
          chk("sb_ovf", 32'(ovf), 32'(e.ovf));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub,
                        input logic [W-1:0] es, input logic ec, input logic eovf, input string tag);
    int n;
    a = ta;
    b = tb;
    sub = tsub;
    in_valid = 1'b1;
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    wait_out(n);
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_s"}, 32'(s), 32'(es));
    chk({tag, "_c"}, 32'(c), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
    tick();
    chk({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
    chk({tag, "_idle_vld"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n;
    int h;
    int nacc;
    int base;

    #1 rst_ni = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_c", 32'(c), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();

    run_op(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, "add");
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple");
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_add");
    run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub");
    run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "ovf_sub");

    // Backpressure: result held while a new request waits
    out_ready = 1'b0;
    a = 16'h1111;
    b = 16'h2222;
    sub = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    chk("bp_lat", n, 4);
    a = 16'h9000;
    b = 16'h1000;
    sub = 1'b1;
    in_valid = 1'b1;
    nacc = acc_cyc.size();
    repeat (3) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_s", 32'(s), 32'h3333);
      chk("bp_c", 32'(c), 32'd0);
      chk("bp_ovf", 32'(ovf), 32'd0);
    end
    chk("bp_no_accept", acc_cyc.size(), nacc);
    out_ready = 1'b1;
    tick();
    h = cyc;
    chk("bp_idle_rdy", 32'(in_ready), 32'd1);
    chk("bp_idle_vld", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("bp_accept_cnt", acc_cyc.size(), nacc + 1);
    chk("bp_accept_cyc", acc_cyc[$], h);
    wait_out(n);
    chk("bp2_lat", n, 4);
    chk("bp2_s", 32'(s), 32'h8000);
    chk("bp2_c", 32'(c), 32'd1);
    chk("bp2_ovf", 32'(ovf), 32'd0);
    tick();

    // Asynchronous reset in CALC with k=2
    a = 16'hAAAA;
    b = 16'h5555;
    sub = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_s", 32'(s), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_c", 32'(c), 32'd0);
    sb.delete();
    a = 16'h0001;
    b = 16'h0001;
    sub = 1'b0;
    in_valid = 1'b1;
    tick();
    rst_ni = 1'b1;
    h = cyc;
    tick();
    in_valid = 1'b0;
    chk("post_rst_accept", acc_cyc[$], h);
    wait_out(n);
    chk("post_rst_lat", n, 4);
    chk("post_rst_s", 32'(s), 32'h0002);
    chk("post_rst_c", 32'(c), 32'd0);
    chk("post_rst_ovf", 32'(ovf), 32'd0);
    tick();

    // Back-to-back stream with out_ready held high
    base = acc_cyc.size();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin a = 16'h00FF; b = 16'h0F01; sub = 1'b0; end
        1: begin a = 16'h0000; b = 16'h0001; sub = 1'b1; end
        default: begin a = 16'hC000; b = 16'hC000; sub = 1'b0; end
      endcase
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
        tick();
        n++;
      end
      chk("b2b_wait", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    tick();
    chk("b2b_drain", sb.size(), 0);
    chk("b2b_count", acc_cyc.size(), base + 3);
    if (acc_cyc.size() >= base + 3) begin
      chk("b2b_gap1", acc_cyc[base + 1] - acc_cyc[base], 6);
      chk("b2b_gap2", acc_cyc[base + 2] - acc_cyc[base + 1], 6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
